seg7_press_counter: RTL and testbench
=====================================

# seg7_press_counter

Two-digit BCD event counter driving the board's pair of directly wired (non-multiplexed) seven-segment displays. It consumes single-cycle event pulses produced by the debounce and edge-detect front end, for example "switch released." It maintains a 00–99 count and renders it as active-low segment patterns. On wrap-around it flashes the display to mark the overflow.

## Interface
- FLASH_CYCLES, 12_500_000, length in CLK cycles of the blanking flash after a wrap; minimum 1.
- WRAP, 1, 1 = count wraps 99↔00; 0 = count saturates at 99 (up) and 00 (down).
- LZ_BLANK, 1, 1 = tens digit blanked while tens == 0; 0 = tens shows "0".
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- i_Incr  input  1  one-cycle increment request.
- i_Decr  input  1  one-cycle decrement request.
- i_Clear  input  1  one-cycle clear request.
- o_Seg_Ones  output  7  ones digit segments, active-low; bit0 = a … bit6 = g.
- o_Seg_Tens  output  7  tens digit segments, same encoding.
- o_Count  output  8  current count as packed BCD, {tens, ones}.
- o_Wrap  output  1  one-cycle pulse on the edge where a wrap occurs.

## Operation
- State:
  - tens and ones BCD registers, each 0–9;
  - flash down-counter, width $clog2(FLASH_CYCLES+1);
  - o_Wrap register;
  - registered segment outputs.
- Per-edge command priority:
  - i_Clear: count ← 00, flash counter ← 0.
  - Otherwise i_Incr and i_Decr both high: no change.
  - Otherwise i_Incr: count + 1.
  - Otherwise i_Decr: count − 1.
  - No request: hold.
- Increment:
  - ones 9 → 0 with carry into tens.
  - At 99: if WRAP, go to 00, pulse o_Wrap, load flash counter with FLASH_CYCLES. If not WRAP, hold 99, no pulse.
- Decrement:
  - ones 0 → 9 with borrow from tens.
  - At 00: if WRAP, go to 99, pulse o_Wrap, load flash counter. If not WRAP, hold 00, no pulse.
- Flash:
  - The counter decrements by 1 per cycle while nonzero.
  - While it is nonzero, both segment outputs are 7'h7F (all off).
  - A wrap during an active flash reloads the counter to FLASH_CYCLES.
  - Clear cancels the flash.
  - Counting continues normally while flashing; o_Count always shows the true value.
- Segment decode, active-low:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex)
- Tens blanking: when LZ_BLANK = 1 and tens = 0, o_Seg_Tens = 7'h7F.
- BCD registers never hold values 10–15. No illegal state is reachable.

## Timing
- Reset (RST_N low, asynchronous; takes effect immediately, mid-flash included):
  - count = 00, flash counter = 0, o_Wrap = 0, o_Count = 8'h00
  - o_Seg_Ones = 7'h40
  - o_Seg_Tens = 7'h7F if LZ_BLANK, else 7'h40
- Release of RST_N needs no special handling. The first edge with RST_N high processes inputs normally.
- Latency: a request sampled at edge N updates o_Count, both segment outputs and o_Wrap at edge N.
  - All outputs are registered, computed from next-state values.
  - No combinational path from inputs to outputs.
- o_Wrap is high for exactly one cycle per wrap. Back-to-back wraps, e.g. alternating incr/decr across the 99/00 boundary, give consecutive pulses.
- Flash length:
  - The wrap edge loads FLASH_CYCLES.
  - Outputs are blank from that edge for exactly FLASH_CYCLES cycles.
  - Segments reappear on edge wrap + FLASH_CYCLES.
- Requests may arrive every cycle. The block imposes no minimum spacing and has no backpressure.

## Test plan
- Reset, then 15 i_Incr pulses on consecutive cycles → o_Count = 8'h15, o_Seg_Tens = 7'h79, o_Seg_Ones = 7'h12, o_Wrap never high.
- WRAP=1, FLASH_CYCLES=4: count to 8'h99, then one i_Incr → same edge o_Count = 8'h00 and o_Wrap = 1 for one cycle. Both segments are 7'h7F for 4 cycles, then o_Seg_Ones = 7'h40 and o_Seg_Tens = 7'h7F.
- WRAP=0: at 8'h99 apply i_Incr ×3 → stays 8'h99, no o_Wrap. From 8'h00 apply i_Decr → stays 8'h00.
- WRAP=1 at 00: i_Decr → 8'h99 with o_Wrap pulse. i_Decr again after 2 cycles (mid-flash) → o_Count = 8'h98 while still blank. Blanking ends 4 cycles after the wrap edge.
- At count 8'h42: i_Incr and i_Decr together → unchanged. i_Clear with i_Incr → 8'h00. i_Clear during an active flash → segments show "0" on the next edge.
- Assert RST_N low asynchronously mid-flash at count 8'h37 → outputs reset to 8'h00 / 7'h40 / 7'h7F immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/seg7_press_counter.sv
// Two-digit BCD press counter driving a pair of active-low seven-segment digits.
// A wrap across 99/00 pulses o_Wrap and blanks both digits for FLASH_CYCLES cycles.
module seg7_press_counter #(
    parameter int unsigned FLASH_CYCLES = 12_500_000,
    parameter bit          WRAP         = 1'b1,
    parameter bit          LZ_BLANK     = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       i_Incr,
    input  logic       i_Decr,
    input  logic       i_Clear,
    output logic [6:0] o_Seg_Ones,
    output logic [6:0] o_Seg_Tens,
    output logic [7:0] o_Count,
    output logic       o_Wrap
);

    localparam int unsigned       FlashW    = $clog2(FLASH_CYCLES + 1);
    localparam logic [FlashW-1:0] FlashLoad = FlashW'(FLASH_CYCLES);
    localparam logic [6:0]        SegBlank  = 7'h7F;
    localparam logic [6:0]        SegZero   = 7'h40;
    localparam logic [6:0]        SegTensRst = LZ_BLANK ? SegBlank : SegZero;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SegBlank;
        endcase
        return seg;
    endfunction

    logic [3:0]        tens_q, tens_d;
    logic [3:0]        ones_q, ones_d;
    logic [FlashW-1:0] flash_q, flash_d;
    logic              wrap_d;
    logic              blank;
    logic [6:0]        seg_ones_d, seg_tens_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        wrap_d = 1'b0;
        if (i_Clear) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (i_Incr && !i_Decr) begin
            if (ones_q != 4'd9) begin
                ones_d = ones_q + 4'd1;
            end else if (tens_q != 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else if (WRAP) begin
                ones_d = 4'd0;
                tens_d = 4'd0;
                wrap_d = 1'b1;
            end
        end else if (i_Decr && !i_Incr) begin
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else if (tens_q != 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else if (WRAP) begin
                ones_d = 4'd9;
                tens_d = 4'd9;
                wrap_d = 1'b1;
            end
        end

        // A wrap always restarts the flash, even one already in progress.
        if (i_Clear) begin
            flash_d = '0;
        end else if (wrap_d) begin
            flash_d = FlashLoad;
        end else if (flash_q != '0) begin
            flash_d = flash_q - 1'b1;
        end else begin
            flash_d = flash_q;
        end

        blank      = (flash_d != '0);
        seg_ones_d = blank ? SegBlank : seg_decode(ones_d);
        seg_tens_d = (blank || (LZ_BLANK && (tens_d == 4'd0))) ? SegBlank : seg_decode(tens_d);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            flash_q    <= '0;
            o_Wrap     <= 1'b0;
            o_Seg_Ones <= SegZero;
            o_Seg_Tens <= SegTensRst;
        end else begin
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            flash_q    <= flash_d;
            o_Wrap     <= wrap_d;
            o_Seg_Ones <= seg_ones_d;
            o_Seg_Tens <= seg_tens_d;
        end
    end

    assign o_Count = {tens_q, ones_q};

endmodule

// File: tb/tb_seg7_press_counter.sv
// Bench for seg7_press_counter: a wrapping/blanking instance and a saturating instance
// share stimulus and are compared each cycle against an integer-count reference model.
module tb_seg7_press_counter;

    localparam int unsigned FC = 4;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b1;
    logic       inc   = 1'b0;
    logic       dec   = 1'b0;
    logic       clr   = 1'b0;
    logic [6:0] so0, st0, so1, st1;
    logic [7:0] c0, c1;
    logic       w0, w1;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;

    // Model: count as plain integer 0..99, blanking as "edge index until which digits are dark".
    int m_cnt   [2];
    int m_until [2];
    bit m_wrap  [2];
    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 CLK = ~CLK;

    seg7_press_counter #(.FLASH_CYCLES(FC), .WRAP(1'b1), .LZ_BLANK(1'b1)) dut_wrap (
        .CLK(CLK), .RST_N(RST_N), .i_Incr(inc), .i_Decr(dec), .i_Clear(clr),
        .o_Seg_Ones(so0), .o_Seg_Tens(st0), .o_Count(c0), .o_Wrap(w0)
    );

    seg7_press_counter #(.FLASH_CYCLES(FC), .WRAP(1'b0), .LZ_BLANK(1'b0)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .i_Incr(inc), .i_Decr(dec), .i_Clear(clr),
        .o_Seg_Ones(so1), .o_Seg_Tens(st1), .o_Count(c1), .o_Wrap(w1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]   = 0;
            m_until[d] = 0;
            m_wrap[d]  = 1'b0;
        end
    endtask

    task automatic model_edge(input bit i, input bit dd, input bit c);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            bit wraps;
            wraps     = (d == 0);
            m_wrap[d] = 1'b0;
            if (c) begin
                m_cnt[d]   = 0;
                m_until[d] = 0;
            end else if (i && !dd) begin
                if (m_cnt[d] < 99) m_cnt[d]++;
                else if (wraps) begin
                    m_cnt[d] = 0;
                    m_wrap[d] = 1'b1;
                end
            end else if (dd && !i) begin
                if (m_cnt[d] > 0) m_cnt[d]--;
                else if (wraps) begin
                    m_cnt[d] = 99;
                    m_wrap[d] = 1'b1;
                end
            end
            if (m_wrap[d]) m_until[d] = cyc + int'(FC);
        end
    endtask

    function automatic logic [7:0] exp_bcd(input int d);
        return {4'(m_cnt[d] / 10), 4'(m_cnt[d] % 10)};
    endfunction

    function automatic logic [7:0] exp_ones(input int d);
        if (cyc < m_until[d]) return 8'h7F;
        return {1'b0, seg_tbl[m_cnt[d] % 10]};
    endfunction

    function automatic logic [7:0] exp_tens(input int d);
        if (cyc < m_until[d]) return 8'h7F;
        if (d == 0 && m_cnt[d] < 10) return 8'h7F;
        return {1'b0, seg_tbl[m_cnt[d] / 10]};
    endfunction

    task automatic check_all();
        chk("wrap_count", c0, exp_bcd(0));
        chk("wrap_seg_ones", {1'b0, so0}, exp_ones(0));
        chk("wrap_seg_tens", {1'b0, st0}, exp_tens(0));
        chk("wrap_pulse", {7'd0, w0}, {7'd0, m_wrap[0]});
        chk("sat_count", c1, exp_bcd(1));
        chk("sat_seg_ones", {1'b0, so1}, exp_ones(1));
        chk("sat_seg_tens", {1'b0, st1}, exp_tens(1));
        chk("sat_pulse", {7'd0, w1}, {7'd0, m_wrap[1]});
    endtask

    task automatic step(input bit i, input bit dd, input bit c);
        @(negedge CLK);
        inc = i;
        dec = dd;
        clr = c;
        @(posedge CLK);
        model_edge(i, dd, c);
        #1;
        check_all();
    endtask

    // Called 1 time unit after a rising edge; asserts and releases reset before the falling edge.
    task automatic async_reset();
        #1;
        RST_N = 1'b0;
        inc   = 1'b0;
        dec   = 1'b0;
        clr   = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_count", c0, 8'h00);
        chk("rst_ones", {1'b0, so0}, 8'h40);
        chk("rst_tens", {1'b0, st0}, 8'h7F);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 RST_N = 1'b0;
        #1 model_reset();
        check_all();
        chk("reset_sat_tens", {1'b0, st1}, 8'h40);
        #1 RST_N = 1'b1;

        repeat (15) step(1'b1, 1'b0, 1'b0);
        chk("plan15_count", c0, 8'h15);
        chk("plan15_tens", {1'b0, st0}, 8'h79);
        chk("plan15_ones", {1'b0, so0}, 8'h12);

        repeat (84) step(1'b1, 1'b0, 1'b0);
        chk("at99", c0, 8'h99);
        step(1'b1, 1'b0, 1'b0);
        chk("wrap_up_count", c0, 8'h00);
        chk("wrap_up_pulse", {7'd0, w0}, 8'h01);
        chk("sat_up_hold", c1, 8'h99);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("still_blank", {1'b0, so0}, 8'h7F);
        step(1'b0, 1'b0, 1'b0);
        chk("flash_end_ones", {1'b0, so0}, 8'h40);
        chk("flash_end_tens", {1'b0, st0}, 8'h7F);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk("sat_99_x3", c1, 8'h99);

        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("wrap_down_count", c0, 8'h99);
        chk("sat_down_hold", c1, 8'h00);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("mid_flash_count", c0, 8'h98);
        chk("mid_flash_blank", {1'b0, so0}, 8'h7F);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        chk("reappear_ones", {1'b0, so0}, 8'h00);
        chk("reappear_tens", {1'b0, st0}, 8'h10);

        // Back-to-back wraps across the 99/00 boundary.
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(k[0] == 1'b1, k[0] == 1'b0, 1'b0);
            chk("b2b_pulse", {7'd0, w0}, 8'h01);
        end

        step(1'b0, 1'b0, 1'b1);
        repeat (42) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("both_hold", c0, 8'h42);
        step(1'b1, 1'b0, 1'b1);
        chk("clear_wins", c0, 8'h00);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("clear_flash_ones", {1'b0, so0}, 8'h40);

        // Async reset in the middle of a flash.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        async_reset();
        repeat (37) step(1'b1, 1'b0, 1'b0);
        chk("at37", c0, 8'h37);
        async_reset();

        repeat (400) begin
            bit ri, rd, rc;
            rc = ($urandom_range(0, 15) == 0);
            ri = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            step(ri, rd, rc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
